// File: rtl/emu_pkg.sv
// rtl/emu_pkg.sv - shared types and register map for the co-emulation transactor
package emu_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HALT} step_state_t;

  localparam logic [7:0] REG_COUNT_LO = 8'h10;
  localparam logic [7:0] REG_COUNT_HI = 8'h11;
  localparam logic [7:0] REG_CTRL     = 8'h12;
  localparam logic [7:0] REG_REM_LO   = 8'h13;
  localparam logic [7:0] REG_REM_HI   = 8'h14;

  localparam int CMD_START   = 0;
  localparam int CMD_ABORT   = 1;
  localparam int CMD_HALT_IO = 2;

  localparam int ST_BUSY     = 0;
  localparam int ST_HALTED   = 1;
  localparam int ST_DONE     = 2;
  localparam int ST_LOAD_ERR = 3;
  localparam int ST_HALT_IO  = 4;

endpackage

// File: rtl/emu_step_ctrl.sv
// rtl/emu_step_ctrl.sv - step engine: run/halt FSM, remaining counter, completion flags
module emu_step_ctrl
  import emu_pkg::*;
#(
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              mode_wr,
  input  logic              mode,
  input  logic              io_req,
  input  logic [STEP_W-1:0] count,
  output logic [STEP_W-1:0] remaining,
  output logic              dut_ce,
  output logic              busy,
  output logic              done,
  output logic              halted_io,
  output logic              halt_on_io
);

  localparam logic [STEP_W-1:0] ONE = {{(STEP_W-1){1'b0}}, 1'b1};

  step_state_t       state, state_nxt;
  logic [STEP_W-1:0] rem_nxt;
  logic              done_nxt, halted_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      remaining  <= '0;
      done       <= 1'b0;
      halted_io  <= 1'b0;
      halt_on_io <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= rem_nxt;
      done      <= done_nxt;
      halted_io <= halted_nxt;
      if (mode_wr) halt_on_io <= mode;
    end
  end

  always_comb begin
    state_nxt  = state;
    rem_nxt    = remaining;
    done_nxt   = done;
    halted_nxt = halted_io;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          halted_nxt = 1'b0;
          if (count != '0) begin
            rem_nxt   = count;
            done_nxt  = 1'b0;
            state_nxt = RUN;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          rem_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          rem_nxt = remaining - ONE;
          // Completion outranks an I/O halt on the final enabled cycle
          if (remaining == ONE) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else if (halt_on_io && io_req) begin
            halted_nxt = 1'b1;
            state_nxt  = HALT;
          end
        end
      end
      HALT: begin
        if (abort) begin
          rem_nxt   = '0;
          state_nxt = IDLE;
        end else if (start) begin
          done_nxt   = 1'b0;
          halted_nxt = 1'b0;
          state_nxt  = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dut_ce = (state == RUN);
  assign busy   = (state == RUN);

endmodule

// File: rtl/emu_transactor.sv
// rtl/emu_transactor.sv - host register window, stimulus/capture buffers and step engine wrapper
module emu_transactor
  import emu_pkg::*;
#(
  parameter int NUM_IN  = 5,
  parameter int NUM_OUT = 5,
  parameter int ADDR_W  = 8,
  parameter int STEP_W  = 16,
  parameter int LED_BIT = 9
) (
  input  logic                 clk_emu,
  input  logic                 reset_n,
  input  logic [7:0]           Data_In,
  input  logic [ADDR_W-1:0]    Addr,
  input  logic                 wr_emu,
  input  logic                 load_emu,
  input  logic                 get_emu,
  output logic [7:0]           Data_Out,
  output logic [NUM_IN*8-1:0]  stim_out,
  input  logic [NUM_OUT*8-1:0] vect_in,
  input  logic                 io_req,
  output logic                 dut_ce,
  output logic                 busy,
  output logic                 clk_LED
);

  logic [NUM_IN*8-1:0]  shadow;
  logic [NUM_OUT*8-1:0] capture;
  logic [STEP_W-1:0]    count, remaining;
  logic [15:0]          count_ext, rem_ext;
  logic [LED_BIT:0]     led_cnt;
  logic [7:0]           status, rd_data;
  logic                 load_err, done, halted_io, halt_on_io;
  logic                 get_act, wr_act, rd_en, cmd_wr, status_rd;

  // Strobe priority: load beats get beats write; reads only when no transfer strobe
  assign get_act   = get_emu && !load_emu;
  assign wr_act    = wr_emu && !load_emu && !get_emu;
  assign rd_en     = !load_emu && !get_emu;
  assign cmd_wr    = wr_act && (Addr == ADDR_W'(REG_CTRL));
  assign status_rd = rd_en && (Addr == ADDR_W'(REG_CTRL));
  assign count_ext = 16'(count);
  assign rem_ext   = 16'(remaining);

  emu_step_ctrl #(.STEP_W(STEP_W)) u_step (
    .clk        (clk_emu),
    .rst_n      (reset_n),
    .start      (cmd_wr && Data_In[CMD_START]),
    .abort      (cmd_wr && Data_In[CMD_ABORT]),
    .mode_wr    (cmd_wr),
    .mode       (Data_In[CMD_HALT_IO]),
    .io_req     (io_req),
    .count      (count),
    .remaining  (remaining),
    .dut_ce     (dut_ce),
    .busy       (busy),
    .done       (done),
    .halted_io  (halted_io),
    .halt_on_io (halt_on_io)
  );

  always_comb begin
    status              = 8'h00;
    status[ST_BUSY]     = busy;
    status[ST_HALTED]   = halted_io;
    status[ST_DONE]     = done;
    status[ST_LOAD_ERR] = load_err;
    status[ST_HALT_IO]  = halt_on_io;
  end

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (Addr == ADDR_W'(i)) rd_data = capture[8*i +: 8];
    end
    if (Addr == ADDR_W'(REG_COUNT_LO)) rd_data = count_ext[7:0];
    if (Addr == ADDR_W'(REG_COUNT_HI)) rd_data = count_ext[15:8];
    if (Addr == ADDR_W'(REG_CTRL))     rd_data = status;
    if (Addr == ADDR_W'(REG_REM_LO))   rd_data = rem_ext[7:0];
    if (Addr == ADDR_W'(REG_REM_HI))   rd_data = rem_ext[15:8];
  end

  always_ff @(posedge clk_emu or negedge reset_n) begin
    if (!reset_n) begin
      shadow   <= '0;
      capture  <= '0;
      stim_out <= '0;
      count    <= '0;
      load_err <= 1'b0;
      Data_Out <= 8'h00;
      led_cnt  <= '0;
    end else begin
      // A load attempted mid-run leaves the DUT inputs alone and is reported instead
      if (load_emu) begin
        if (busy) load_err <= 1'b1;
        else      stim_out <= shadow;
      end else if (status_rd) begin
        load_err <= 1'b0;
      end
      if (get_act) capture <= vect_in;
      if (wr_act) begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (Addr == ADDR_W'(i)) shadow[8*i +: 8] <= Data_In;
        end
        if (Addr == ADDR_W'(REG_COUNT_LO))
          count <= STEP_W'({count_ext[15:8], Data_In});
        if ((STEP_W > 8) && (Addr == ADDR_W'(REG_COUNT_HI)))
          count <= STEP_W'({Data_In, count_ext[7:0]});
      end
      if (rd_en) Data_Out <= rd_data;
      if (dut_ce) led_cnt <= led_cnt + {{LED_BIT{1'b0}}, 1'b1};
    end
  end

  assign clk_LED = led_cnt[LED_BIT];

endmodule

// File: tb/tb_emu_transactor.sv
// tb/tb_emu_transactor.sv - self-checking bench for emu_transactor
module tb_emu_transactor;

  localparam int NUM_IN  = 5;
  localparam int NUM_OUT = 5;
  localparam int ADDR_W  = 8;
  localparam int STEP_W  = 16;
  localparam int LED_BIT = 9;

  logic                 clk_emu = 1'b0;
  logic                 reset_n = 1'b0;
  logic [7:0]           Data_In = 8'h00;
  logic [ADDR_W-1:0]    Addr = '0;
  logic                 wr_emu = 1'b0, load_emu = 1'b0, get_emu = 1'b0;
  logic [7:0]           Data_Out;
  logic [NUM_IN*8-1:0]  stim_out;
  logic [NUM_OUT*8-1:0] vect_in = '0;
  logic                 io_req = 1'b0;
  logic                 dut_ce, busy, clk_LED;

  emu_transactor #(
    .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .ADDR_W(ADDR_W), .STEP_W(STEP_W), .LED_BIT(LED_BIT)
  ) dut (
    .clk_emu(clk_emu), .reset_n(reset_n), .Data_In(Data_In), .Addr(Addr),
    .wr_emu(wr_emu), .load_emu(load_emu), .get_emu(get_emu), .Data_Out(Data_Out),
    .stim_out(stim_out), .vect_in(vect_in), .io_req(io_req), .dut_ce(dut_ce),
    .busy(busy), .clk_LED(clk_LED)
  );

  always #5 clk_emu = ~clk_emu;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: byte-level view of the host-visible state
  logic [7:0]           m_shadow [NUM_IN];
  logic [NUM_IN*8-1:0]  m_stim;
  logic [NUM_OUT*8-1:0] m_cap;
  logic [15:0]          m_count;
  int                   m_led;

  typedef struct packed {
    logic       is_wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_emu);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    Addr = a; Data_In = d; wr_emu = 1'b1;
    tick();
    wr_emu = 1'b0;
    for (int i = 0; i < NUM_IN; i++) if (a == 8'(i)) m_shadow[i] = d;
    if (a == 8'h10) m_count[7:0] = d;
    if (a == 8'h11) m_count[15:8] = d;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    Addr = a;
    tick();
    chk(name, 64'(Data_Out), 64'(exp));
  endtask

  task automatic pulse_load();
    load_emu = 1'b1;
    tick();
    load_emu = 1'b0;
  endtask

  task automatic pulse_get();
    get_emu = 1'b1;
    tick();
    get_emu = 1'b0;
  endtask

  task automatic count_ce(input int budget, output int n);
    n = 0;
    while (dut_ce === 1'b1 && n < budget) begin
      n++;
      tick();
    end
  endtask

  task automatic run(input int cnt);
    int n;
    wr(8'h10, 8'(cnt));
    wr(8'h11, 8'(cnt >> 8));
    wr(8'h12, 8'h01);
    count_ce(cnt + 8, n);
    chk("run_pulses", 64'(n), 64'(cnt));
    m_led += cnt;
  endtask

  function automatic logic [7:0] exp_rd(input int a);
    if (a < NUM_OUT) return m_cap[8*a +: 8];
    if (a == 16) return m_count[7:0];
    if (a == 17) return m_count[15:8];
    return 8'h00;
  endfunction

  function automatic logic [NUM_IN*8-1:0] pack_shadow();
    logic [NUM_IN*8-1:0] p;
    for (int i = 0; i < NUM_IN; i++) p[8*i +: 8] = m_shadow[i];
    return p;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] cap_exp [NUM_OUT];
    int n;

    tbl[0]  = '{1'b0, 8'h12, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 8'h13, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 8'h14, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 8'h10, 8'h00, 8'h00};
    tbl[4]  = '{1'b1, 8'h10, 8'hA5, 8'h00};
    tbl[5]  = '{1'b1, 8'h11, 8'h3C, 8'h00};
    tbl[6]  = '{1'b0, 8'h10, 8'h00, 8'hA5};
    tbl[7]  = '{1'b0, 8'h11, 8'h00, 8'h3C};
    tbl[8]  = '{1'b1, 8'h1F, 8'h77, 8'h00};
    tbl[9]  = '{1'b0, 8'h1F, 8'h00, 8'h00};
    tbl[10] = '{1'b0, 8'h15, 8'h00, 8'h00};
    tbl[11] = '{1'b1, 8'h00, 8'h11, 8'h00};
    tbl[12] = '{1'b1, 8'h01, 8'h22, 8'h00};
    tbl[13] = '{1'b1, 8'h02, 8'h33, 8'h00};
    tbl[14] = '{1'b1, 8'h03, 8'h44, 8'h00};
    tbl[15] = '{1'b1, 8'h04, 8'h55, 8'h00};
    cap_exp = '{8'hE5, 8'hD4, 8'hC3, 8'hB2, 8'hA1};

    for (int i = 0; i < NUM_IN; i++) m_shadow[i] = 8'h00;
    m_stim = '0; m_cap = '0; m_count = 16'h0000; m_led = 0;

    // Reset state
    tick(); tick();
    chk("rst_stim", 64'(stim_out), 64'h0);
    chk("rst_dut_ce", 64'(dut_ce), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_led", 64'(clk_LED), 64'h0);
    chk("rst_data_out", 64'(Data_Out), 64'h0);
    reset_n = 1'b1;
    tick();

    // Register table
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data);
      else rd(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // Stimulus load and capture
    chk("stim_pre_load", 64'(stim_out), 64'h0);
    pulse_load();
    m_stim = pack_shadow();
    chk("stim_load", 64'(stim_out), 64'h5544332211);
    vect_in = 40'hA1B2C3D4E5;
    pulse_get();
    m_cap = vect_in;
    for (int i = 0; i < NUM_OUT; i++) rd(8'(i), cap_exp[i], "cap_rd");

    // Three-cycle run
    run(3);
    rd(8'h12, 8'h04, "run3_status");
    rd(8'h13, 8'h00, "run3_rem");

    // Halt on I/O request in the 4th enabled cycle, then resume
    wr(8'h10, 8'h0A); wr(8'h11, 8'h00); wr(8'h12, 8'h05);
    n = 0;
    while (dut_ce === 1'b1 && n < 20) begin
      n++;
      if (n == 4) io_req = 1'b1;
      tick();
      io_req = 1'b0;
    end
    chk("halt_pulses", 64'(n), 64'd4);
    rd(8'h12, 8'h12, "halt_status");
    rd(8'h13, 8'h06, "halt_rem");
    wr(8'h12, 8'h01);
    count_ce(20, n);
    chk("resume_pulses", 64'(n), 64'd6);
    rd(8'h12, 8'h04, "resume_status");
    m_led += 10;

    // Abort after five enabled cycles
    wr(8'h10, 8'h00); wr(8'h11, 8'h01); wr(8'h12, 8'h01);
    tick(); tick(); tick(); tick();
    chk("abort_ce_before", 64'(dut_ce), 64'h1);
    wr(8'h12, 8'h02);
    chk("abort_ce_after", 64'(dut_ce), 64'h0);
    rd(8'h12, 8'h00, "abort_status");
    rd(8'h13, 8'h00, "abort_rem_lo");
    rd(8'h14, 8'h00, "abort_rem_hi");
    m_led += 5;

    // START with zero count only sets done
    wr(8'h10, 8'h00); wr(8'h11, 8'h00); wr(8'h12, 8'h01);
    chk("zero_ce", 64'(dut_ce), 64'h0);
    rd(8'h12, 8'h04, "zero_status");

    // START and ABORT together: ABORT wins
    wr(8'h10, 8'h05); wr(8'h12, 8'h03);
    chk("start_abort_ce", 64'(dut_ce), 64'h0);
    rd(8'h13, 8'h00, "start_abort_rem");

    // load_emu during RUN
    wr(8'h10, 8'h14); wr(8'h12, 8'h01);
    wr(8'h00, 8'h99);
    chk("lerr_busy", 64'(busy), 64'h1);
    pulse_load();
    chk("lerr_stim", 64'(stim_out), 64'(m_stim));
    count_ce(30, n);
    chk("lerr_pulses", 64'(n + 2), 64'd20);
    rd(8'h12, 8'h0C, "lerr_status1");
    rd(8'h12, 8'h04, "lerr_status2");
    m_led += 20;

    // Randomized traffic against the model
    for (int it = 0; it < 150; it++) begin
      int op, a, r;
      op = int'($urandom_range(0, 5));
      case (op)
        0: wr(8'($urandom_range(0, NUM_IN - 1)), 8'($urandom));
        1: begin
          pulse_load();
          m_stim = pack_shadow();
          chk("rnd_load", 64'(stim_out), 64'(m_stim));
        end
        2: begin
          vect_in = 40'({$urandom, $urandom});
          pulse_get();
          m_cap = vect_in;
        end
        3: begin
          r = int'($urandom_range(0, 9));
          a = (r < 8) ? r : ((r == 8) ? 16 : 17);
          rd(8'(a), exp_rd(a), "rnd_read");
        end
        4: begin
          run(int'($urandom_range(1, 12)));
          chk("rnd_led", 64'(clk_LED), 64'((m_led >> LED_BIT) & 1));
        end
        default: begin
          Addr = 8'($urandom_range(0, NUM_IN - 1));
          Data_In = 8'($urandom);
          wr_emu = 1'b1;
          if ($urandom_range(0, 1) == 1) begin
            load_emu = 1'b1;
            tick();
            m_stim = pack_shadow();
            chk("prio_load", 64'(stim_out), 64'(m_stim));
          end else begin
            vect_in = 40'({$urandom, $urandom});
            get_emu = 1'b1;
            tick();
            m_cap = vect_in;
          end
          wr_emu = 1'b0; load_emu = 1'b0; get_emu = 1'b0;
        end
      endcase
    end
    pulse_load();
    m_stim = pack_shadow();
    chk("rnd_final_load", 64'(stim_out), 64'(m_stim));

    // Long run so the LED bit toggles
    run(520);
    chk("led_long", 64'(clk_LED), 64'((m_led >> LED_BIT) & 1));

    // Asynchronous reset mid-run
    wr(8'h10, 8'h32); wr(8'h11, 8'h00); wr(8'h12, 8'h01);
    tick(); tick();
    chk("ce_before_rst", 64'(dut_ce), 64'h1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_ce", 64'(dut_ce), 64'h0);
    chk("async_rst_busy", 64'(busy), 64'h0);
    chk("async_rst_led", 64'(clk_LED), 64'h0);
    tick();
    reset_n = 1'b1;
    chk("post_rst_stim", 64'(stim_out), 64'h0);
    rd(8'h10, 8'h00, "post_rst_count");
    rd(8'h12, 8'h00, "post_rst_status");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/emu_transactor.md
# emu_transactor

Parametrised, single-clock host-to-DUT co-emulation transactor. It is the successor to the fixed five-byte stimulus/capture wrapper. It provides `NUM_IN` double-buffered stimulus bytes, `NUM_OUT` capture bytes and a command/status register window. A step engine drives the DUT clock-enable for a programmed number of cycles, optionally halting early when the DUT raises an I/O request. It sits between the byte-wide host emulation port and a clock-enabled DUT instance.

## Interface
- `NUM_IN`, 5: stimulus byte count (1..16).
- `NUM_OUT`, 5: capture byte count (1..16).
- `ADDR_W`, 8: host address width (≥ 5).
- `STEP_W`, 16: step counter width (8 or 16).
- `LED_BIT`, 9: counter bit driven to `clk_LED`.
- `clk_emu` in 1: sole clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `Data_In` in 8: host write data.
- `Addr` in `ADDR_W`: host register address.
- `wr_emu` in 1: host write strobe.
- `load_emu` in 1: transfer the stimulus shadow to the DUT-facing registers.
- `get_emu` in 1: snapshot DUT outputs into the capture registers.
- `Data_Out` out 8: registered host read data.
- `stim_out` out `NUM_IN*8`: DUT-facing stimulus; byte i is at `[8i+7:8i]`.
- `vect_in` in `NUM_OUT*8`: DUT outputs.
- `io_req` in 1: DUT I/O request (halt condition).
- `dut_ce` out 1: DUT clock enable.
- `busy` out 1: high in RUN.
- `clk_LED` out 1: activity indicator.

## Operation
- Register map:
  - Addresses 0..`NUM_IN`-1: stimulus shadow on write, capture byte on read.
  - `0x10`: step count low byte (R/W).
  - `0x11`: step count high byte (R/W; absent if `STEP_W`=8).
  - `0x12` write command: bit0 START, bit1 ABORT, bit2 HALT_ON_IO (latched mode).
  - `0x12` read status: bit0 busy, bit1 halted_io, bit2 done, bit3 load_err, bit4 HALT_ON_IO.
  - `0x13`: remaining count low byte (RO).
  - `0x14`: remaining count high byte (RO).
  - Other addresses read `0x00`; writes to them are ignored.
- Host strobe priority: `load_emu` > `get_emu` > `wr_emu`. Only the highest active strobe acts in a cycle.
- Reads use `Addr` every cycle in which neither `load_emu` nor `get_emu` is high.
- `load_emu`:
  - In IDLE or HALT, copies all shadows to `stim_out`.
  - In RUN it is ignored and sets sticky `load_err`. `load_err` clears on a status read.
- `get_emu` captures `vect_in` in any state.
- Step FSM states:
  - IDLE: on START with count ≠ 0, load remaining ← count and go to RUN. START with count = 0 sets `done` and stays in IDLE.
  - RUN: `dut_ce`=1, remaining decrements each cycle. When remaining = 1, go to IDLE and set `done`.
  - RUN, early halt: if HALT_ON_IO and `io_req` is sampled 1 (after that cycle's enable), go to HALT and set `halted_io`.
  - HALT: `dut_ce`=0 and remaining is held. START resumes to RUN without reloading. ABORT goes to IDLE.
  - ABORT in RUN goes to IDLE next cycle. `done` is not set and remaining is zeroed.
- START clears `done` and `halted_io`.
- The count register is unchanged by stepping, so it can be reused for repeated runs.
- Remaining decrements modulo 2^`STEP_W`. Programming all-ones runs 2^`STEP_W`−1 cycles.
- The LED counter increments only on `dut_ce` cycles and wraps freely.

## Timing
- Reset values:
  - `Data_Out`, `stim_out`, `dut_ce`, `busy` and `clk_LED` are 0.
  - Shadows, capture registers, count, remaining and all flags are 0.
  - HALT_ON_IO is 0; the FSM is in IDLE.
- Read latency is 1 cycle: the `Addr` sampled at edge t appears on `Data_Out` after edge t.
- `load_emu` at edge t updates `stim_out` after edge t.
- START written at edge t: `dut_ce` is high for cycles t+1 … t+N, exactly N cycles. `busy` mirrors `dut_ce` in RUN.
- `io_req` high in RUN cycle k: cycle k is enabled; `dut_ce`=0 from k+1.
- Simultaneous START and ABORT: ABORT wins.
- START while in RUN is ignored.
- `reset_n` asserted mid-run forces `dut_ce` to 0 immediately (asynchronously).

## Structure
- Package `emu_pkg`:
  - FSM enum `{IDLE, RUN, HALT}`.
  - Register address constants `0x10`–`0x14`.
  - Command and status bit indices.
- Sub-module `emu_step_ctrl`: FSM, remaining counter, flags, `dut_ce`/`busy`.
- Top level: register file, strobe priority, read mux, LED counter.

## Test plan
- Reset, then read 0x12 → `0x00`; `stim_out` and `dut_ce` are 0.
- Write stim 0..4 = `0x11..0x55`, then pulse `load_emu` → `stim_out` = `0x5544332211`. Drive `vect_in` = `0xA1B2C3D4E5` and pulse `get_emu` → reads of addr 0..4 return `0xE5,0xD4,0xC3,0xB2,0xA1`.
- Count = 3, START → exactly 3 `dut_ce` cycles; status = `0x04`; remaining = 0.
- Count = 10, HALT_ON_IO | START, `io_req` high in the 4th enabled cycle → 4 pulses; status = `0x12`; remaining = 6. START again → 6 more pulses; done is set.
- Count = 0x0100, START, ABORT after 5 cycles → `dut_ce` drops the next cycle; done = 0; remaining = 0.
- `load_emu` during RUN → `stim_out` is unchanged and `load_err` is set. A second status read returns bit3 = 0.
